// File: rtl/gmii_rx_deframer.sv
// GMII/MII receive deframer: strips preamble/SFD, checks CRC-32, and streams the
// payload with the 4 FCS bytes removed through a 5-byte delay line.
module gmii_rx_deframer #(
    parameter int MAX_LEN = 1522
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       mii_select,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_frame_good,
    output logic       stat_bad_fcs,
    output logic       stat_bad_frame
);

    localparam logic [1:0]  IDLE        = 2'd0;
    localparam logic [1:0]  PREAMBLE    = 2'd1;
    localparam logic [1:0]  PAYLOAD     = 2'd2;
    localparam logic [1:0]  DROP        = 2'd3;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // Input sampling; smp marks a cycle carrying a fresh enabled sample.
    logic [7:0] rxd_r;
    logic       dv_r, er_r, smp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_r <= '0;
            dv_r  <= 1'b0;
            er_r  <= 1'b0;
            smp   <= 1'b0;
        end else begin
            smp <= clk_en;
            if (clk_en) begin
                rxd_r <= gmii_rxd;
                dv_r  <= gmii_rx_dv;
                er_r  <= gmii_rx_er;
            end
        end
    end

    // Byte assembly: one event per sample, ev_byte only when a full byte is ready.
    logic       phase;
    logic [3:0] lo_nib;
    logic       ev_vld, ev_dv, ev_byte, ev_er, ev_odd;
    logic [7:0] ev_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= 1'b0;
            lo_nib  <= '0;
            ev_vld  <= 1'b0;
            ev_dv   <= 1'b0;
            ev_byte <= 1'b0;
            ev_er   <= 1'b0;
            ev_odd  <= 1'b0;
            ev_data <= '0;
        end else begin
            ev_vld  <= smp;
            ev_byte <= 1'b0;
            ev_odd  <= 1'b0;
            if (smp) begin
                ev_dv <= dv_r;
                ev_er <= er_r & dv_r;
                if (!dv_r) begin
                    ev_odd <= mii_select & phase;
                    phase  <= 1'b0;
                end else if (mii_select) begin
                    phase <= ~phase;
                    if (!phase) begin
                        lo_nib <= rxd_r[3:0];
                    end else begin
                        ev_byte <= 1'b1;
                        ev_data <= {rxd_r[3:0], lo_nib};
                    end
                end else begin
                    ev_byte <= 1'b1;
                    ev_data <= rxd_r;
                end
            end
        end
    end

    logic [1:0]      state;
    logic            armed;
    logic [15:0]     cnt;
    logic [31:0]     crc;
    logic            er_seen;
    logic [4:0][7:0] dl;
    logic            fcs_bad, other_bad;

    assign fcs_bad   = (crc != CRC_RESIDUE);
    assign other_bad = er_seen | ev_odd | (32'(cnt) > 32'(MAX_LEN));

    // armed blocks the tail of a frame cut by reset from being parsed as a new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            armed           <= 1'b0;
            cnt             <= '0;
            crc             <= CRC_INIT;
            er_seen         <= 1'b0;
            dl              <= '0;
            m_axis_tdata    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            stat_frame_good <= 1'b0;
            stat_bad_fcs    <= 1'b0;
            stat_bad_frame  <= 1'b0;
        end else begin
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            stat_frame_good <= 1'b0;
            stat_bad_fcs    <= 1'b0;
            stat_bad_frame  <= 1'b0;
            if (ev_vld) begin
                if (!ev_dv) armed <= 1'b1;
                case (state)
                    IDLE, PREAMBLE: begin
                        if (!ev_dv) begin
                            state <= IDLE;
                        end else if (state == PREAMBLE || armed) begin
                            if (ev_er || (ev_byte && ev_data != 8'h55 && ev_data != 8'hD5)) begin
                                state          <= DROP;
                                stat_bad_frame <= 1'b1;
                            end else if (ev_byte && ev_data == 8'hD5) begin
                                state   <= PAYLOAD;
                                cnt     <= '0;
                                crc     <= CRC_INIT;
                                er_seen <= 1'b0;
                                dl      <= '0;
                            end else begin
                                state <= PREAMBLE;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (!ev_dv) begin
                            state <= IDLE;
                            if (cnt >= 16'd5) begin
                                m_axis_tdata    <= dl[4];
                                m_axis_tvalid   <= 1'b1;
                                m_axis_tlast    <= 1'b1;
                                m_axis_tuser    <= fcs_bad | other_bad;
                                stat_frame_good <= ~fcs_bad & ~other_bad;
                                stat_bad_fcs    <= fcs_bad & ~other_bad;
                                stat_bad_frame  <= other_bad;
                            end else begin
                                stat_bad_frame <= 1'b1;
                            end
                        end else begin
                            if (ev_er) er_seen <= 1'b1;
                            if (ev_byte) begin
                                dl  <= {dl[3:0], ev_data};
                                crc <= crc_byte(crc, ev_data);
                                if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
                                if (cnt >= 16'd5) begin
                                    m_axis_tdata  <= dl[4];
                                    m_axis_tvalid <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        if (!ev_dv) state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/gmii_rx_deframer.md
GMII_RX_DEFRAMER -- requirements
Module: gmii_rx_deframer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1522, meaning the maximum post-SFD byte count, FCS included, accepted as a good frame.
REQ-002 SHALL have port clk, input, 1 bit: receive clock, the same net as the PHY-interface GMII rx clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port clk_en, input, 1: sample enable; tie to 1 for 1000M.
REQ-005 SHALL have port mii_select, input, 1: 1 = 10/100 nibble mode, using rxd[3:0] only.
REQ-006 SHALL have port gmii_rxd, input, 8: receive data.
REQ-007 SHALL have port gmii_rx_dv, input, 1: data valid.
REQ-008 SHALL have port gmii_rx_er, input, 1: receive error.
REQ-009 SHALL have port m_axis_tdata, output, 8: payload byte, FCS stripped.
REQ-010 SHALL have port m_axis_tvalid, output, 1: byte valid; the stream has no tready and never stalls.
REQ-011 SHALL have port m_axis_tlast, output, 1: last payload byte of the frame.
REQ-012 SHALL have port m_axis_tuser, output, 1: bad frame; meaningful only with tlast.
REQ-013 SHALL have ports stat_frame_good, stat_bad_fcs and stat_bad_frame, outputs, 1 bit each: single-cycle event pulses.

Function
REQ-014 SHALL register rxd, dv and er on clk edges where clk_en=1; cycles with clk_en=0 SHALL change no state.
REQ-015 In nibble mode SHALL assemble bytes low nibble first from two enabled samples; nibble phase SHALL reset whenever dv=0.
REQ-016 SHALL implement the FSM states IDLE, PREAMBLE, PAYLOAD and DROP.
- IDLE -> PREAMBLE on dv=1.
- PREAMBLE: byte 0x55 stays; 0xD5 -> PAYLOAD; any other byte, or er=1 -> DROP; dv=0 -> IDLE silently.
- PAYLOAD -> IDLE on dv=0 (frame end).
- DROP -> IDLE on the first enabled sample with dv=0.
REQ-017 In PAYLOAD, SHALL feed every byte into a 5-byte delay line and into CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, no final XOR).
REQ-018 On receipt of payload byte B(n+5), SHALL emit B(n) with tvalid=1 and tlast=0, so the 4 FCS bytes never reach the output.
REQ-019 Latency SHALL be tvalid asserted on the 2nd clk edge after the edge sampling the completing byte (byte-complete in nibble mode).
REQ-020 At frame end with count>=5, SHALL emit the oldest held byte with tlast=1.
- tuser=1 if CRC register != 0xDEBB20E3, er was seen in the frame, count>MAX_LEN, or nibble mode ended on an odd nibble.
- Otherwise tuser=0.
REQ-021 At frame end with count<5 (runt), SHALL produce no stream output and pulse stat_bad_frame.
REQ-022 The post-SFD byte counter SHALL be 16 bits and saturate at 0xFFFF, never wrapping.
REQ-023 Stats pulse 1 cycle coincident with the tlast beat.
- Good frame: stat_frame_good.
- CRC mismatch only: stat_bad_fcs.
- Any other tuser cause: stat_bad_frame.
REQ-024 Entry to DROP from PREAMBLE SHALL pulse stat_bad_frame once and emit nothing.
REQ-025 dv reasserting while in DROP SHALL be ignored; a new frame requires dv=0 first.
REQ-026 A frame with dv=1 and er=1 and no data bytes SHALL be treated as a runt.

Reset
REQ-027 On rst=1, all outputs SHALL go to 0 immediately, FSM to IDLE, delay line and counter cleared, CRC set to 0xFFFFFFFF, nibble phase cleared.
REQ-028 Reset mid-frame SHALL discard the frame with no tlast emitted; after release, the remainder of that frame (no SFD) SHALL be ignored until dv=0.

Verification
REQ-029 1000M, 7x0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS -> 60 beats 0x00..0x3B, tlast on 0x3B, tuser=0, one stat_frame_good pulse.
REQ-030 Same frame with FCS byte 0 XOR 0x01 -> 60 beats, tlast tuser=1, stat_bad_fcs pulse only.
REQ-031 er=1 for one sample at payload byte 20 -> 60 beats, tlast tuser=1, stat_bad_frame pulse.
REQ-032 Preamble byte 0x5A before SFD -> no tvalid, one stat_bad_frame pulse, FSM returns to IDLE after dv=0.
REQ-033 mii_select=1, clk_en high 1 of 5 cycles, 64-byte frame sent as nibbles -> 60 beats identical to REQ-029.
REQ-034 Runt cases:
- 3-byte post-SFD frame -> no tvalid, stat_bad_frame pulse.
- rst asserted at payload byte 30, then released -> outputs 0, no tlast; next full frame received correctly.
